// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beta_pkg
// Description : Shared types and constants for the destination-tag tracker.
//               A tag is {result class[6:5], destination register[4:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package beta_pkg;

  typedef logic [6:0] tag_t;

  typedef enum logic [1:0] {
    CLS_LD   = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_LINK = 2'b10,
    CLS_NONE = 2'b11
  } res_class_e;

  localparam logic [4:0] R31        = 5'd31;
  localparam tag_t       BUBBLE_TAG = {CLS_NONE, R31};

  // Build a tag from a class and a register number.
  function automatic tag_t make_tag(input logic [1:0] cls, input logic [4:0] rc);
    return {cls, rc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/beta_dest_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : beta_dest_tracker_if
// Description : Decode-side inputs, pipeline control and bypass/writeback
//               outputs of the destination-tag tracker.
//               master = pipeline/bypass side, slave = tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface beta_dest_tracker_if;
  import beta_pkg::*;

  logic       id_valid;
  logic [4:0] id_rc;
  logic [1:0] id_class;
  logic       stall;
  logic       mem_wait;
  logic       annul;
  tag_t       aP0;
  tag_t       aP1;
  tag_t       aP2;
  logic       wb_we;
  logic [4:0] wb_addr;

  modport master (
    output id_valid, id_rc, id_class, stall, mem_wait, annul,
    input  aP0, aP1, aP2, wb_we, wb_addr
  );

  modport slave (
    input  id_valid, id_rc, id_class, stall, mem_wait, annul,
    output aP0, aP1, aP2, wb_we, wb_addr
  );

endinterface
`default_nettype wire

// File: rtl/beta_tag_stage.sv
`default_nettype none
// ============================================================================
// Module      : beta_tag_stage
// Description : One destination-tag pipeline register. Hold has priority
//               over bubble insertion, which has priority over loading d.
//               Resets to the bubble tag.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_tag_stage
  import beta_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic insert_bubble,
  input  tag_t d,
  output tag_t q
);

  tag_t tag_d;
  tag_t tag_q;

  // Next tag: freeze, squash to bubble, or advance.
  always_comb begin
    tag_d = d;
    if (hold) begin
      tag_d = tag_q;
    end else if (insert_bubble) begin
      tag_d = BUBBLE_TAG;
    end
  end

  // Tag register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= BUBBLE_TAG;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q = tag_q;

endmodule
`default_nettype wire

// File: rtl/beta_dest_tracker.sv
`default_nettype none
// ============================================================================
// Module      : beta_dest_tracker
// Description : Carries destination tags of issued instructions through the
//               ALU, MEM and WB stages, publishes them to the bypass unit and
//               drives the register-file write port at WB. Handles load-use
//               stall, memory-wait freeze and branch annul.
//               Optional stall/annul statistics counters are built when the
//               macro BETA_TRACK_STATS_EN is defined; otherwise the counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_dest_tracker
  import beta_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  beta_dest_tracker_if.slave   bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     annul_cnt
);

  tag_t dec_tag;
  tag_t tag_alu;
  tag_t tag_mem;
  tag_t tag_wb;
  logic bubble_alu;

  // Decode tag: anything that does not produce a real register write
  // (invalid, annulled, class NONE, or a write to the hardwired R31) is a bubble.
  always_comb begin
    dec_tag = BUBBLE_TAG;
    if (bus.id_valid && !bus.annul &&
        (bus.id_class != CLS_NONE) && (bus.id_rc != R31)) begin
      dec_tag = make_tag(bus.id_class, bus.id_rc);
    end
  end

  // Stall and annul both push a bubble into ALU; mem_wait hold dominates
  // inside the stage itself.
  assign bubble_alu = bus.stall | bus.annul;

  beta_tag_stage u_stage_alu (
    .clk           (clk),
    .reset         (reset),
    .hold          (bus.mem_wait),
    .insert_bubble (bubble_alu),
    .d             (dec_tag),
    .q             (tag_alu)
  );

  beta_tag_stage u_stage_mem (
    .clk           (clk),
    .reset         (reset),
    .hold          (bus.mem_wait),
    .insert_bubble (1'b0),
    .d             (tag_alu),
    .q             (tag_mem)
  );

  beta_tag_stage u_stage_wb (
    .clk           (clk),
    .reset         (reset),
    .hold          (bus.mem_wait),
    .insert_bubble (1'b0),
    .d             (tag_mem),
    .q             (tag_wb)
  );

  assign bus.aP0     = tag_alu;
  assign bus.aP1     = tag_mem;
  assign bus.aP2     = tag_wb;
  // The WB write is deferred while memory is busy; the held tag writes on
  // the first cycle mem_wait is low.
  assign bus.wb_we   = !bus.mem_wait && (tag_wb[6:5] != CLS_NONE);
  assign bus.wb_addr = tag_wb[4:0];

  // The pipeline is built for exactly three tag stages.
  always_ff @(posedge clk) begin
    assert (NSTAGE == 3) else $error("beta_dest_tracker supports NSTAGE == 3 only");
  end

`ifdef BETA_TRACK_STATS_EN
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] annul_cnt_d;
  logic [CNT_W-1:0] annul_cnt_q;
  logic             stall_hit;
  logic             annul_hit;

  // An annul only counts when it actually kills the decode slot.
  assign stall_hit = bus.stall && !bus.mem_wait;
  assign annul_hit = bus.annul && !bus.stall && !bus.mem_wait;

  // Saturating increments.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    annul_cnt_d = annul_cnt_q;
    if (stall_hit && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (annul_hit && (annul_cnt_q != {CNT_W{1'b1}})) begin
      annul_cnt_d = annul_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      annul_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      annul_cnt_q <= annul_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign annul_cnt = annul_cnt_q;
`else
  assign stall_cnt = '0;
  assign annul_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_beta_dest_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_beta_dest_tracker
// Description : Directed self-checking bench for beta_dest_tracker.
//               Counter expectations follow BETA_TRACK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beta_dest_tracker;
  import beta_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [6:0] BUB = 7'h7F;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] annul_cnt;
  int               checks;
  int               errors;

  beta_dest_tracker_if bus ();

  beta_dest_tracker #(.NSTAGE(3), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .annul_cnt (annul_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: zero when statistics are not built.
  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef BETA_TRACK_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rc, input logic [1:0] cls,
                       input logic st, input logic mw, input logic an);
    bus.id_valid = v;
    bus.id_rc    = rc;
    bus.id_class = cls;
    bus.stall    = st;
    bus.mem_wait = mw;
    bus.annul    = an;
  endtask

  task automatic check_tags(input string tag, input logic [6:0] e0,
                            input logic [6:0] e1, input logic [6:0] e2);
    check({tag, ".aP0"}, 32'(bus.aP0), 32'(e0));
    check({tag, ".aP1"}, 32'(bus.aP1), 32'(e1));
    check({tag, ".aP2"}, 32'(bus.aP2), 32'(e2));
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] addr);
    check({tag, ".we"}, 32'(bus.wb_we), 32'(we));
    if (we) check({tag, ".addr"}, 32'(bus.wb_addr), 32'(addr));
  endtask

  // Safety net in case the run stalls unexpectedly.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_tags("rst", BUB, BUB, BUB);
    check("rst.we", 32'(bus.wb_we), 32'd0);
    check("rst.addr", 32'(bus.wb_addr), 32'd31);
    check("rst.scnt", stall_cnt, 32'd0);
    check("rst.acnt", annul_cnt, 32'd0);

    // ALU r3 travels to WB in three cycles
    drive(1'b1, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    check_tags("alu.c1", 7'h23, BUB, BUB);
    check_wb("alu.c1", 1'b0, 5'd0);
    tick();
    check_tags("alu.c2", BUB, 7'h23, BUB);
    tick();
    check_tags("alu.c3", BUB, BUB, 7'h23);
    check_wb("alu.c3", 1'b1, 5'd3);
    tick();
    check_wb("alu.c4", 1'b0, 5'd0);

    // LD r5 then dependent ALU r6 held by two stall cycles
    drive(1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    check_tags("ld.c1", 7'h05, BUB, BUB);
    drive(1'b1, 5'd6, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    check_tags("ld.c2", BUB, 7'h05, BUB);
    tick();
    check_tags("ld.c3", BUB, BUB, 7'h05);
    check_wb("ld.c3", 1'b1, 5'd5);
    drive(1'b1, 5'd6, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check_tags("ld.c4", 7'h26, BUB, BUB);
    check("ld.scnt", stall_cnt, cexp(32'd2));
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Fill pipe r7/r8/r10 then freeze for three cycles (stall ignored)
    drive(1'b1, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check_tags("mw.full", 7'h2A, 7'h28, 7'h27);
    drive(1'b1, 5'd11, 2'b01, 1'b1, 1'b1, 1'b0);
    #1;
    check_wb("mw.c0", 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_tags($sformatf("mw.w%0d", i), 7'h2A, 7'h28, 7'h27);
      check_wb($sformatf("mw.w%0d", i), 1'b0, 5'd0);
    end
    check("mw.scnt", stall_cnt, cexp(32'd2));
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    check_wb("mw.rel", 1'b1, 5'd7);
    tick();
    check_tags("mw.adv", BUB, 7'h2A, 7'h28);
    check_wb("mw.adv", 1'b1, 5'd8);
    repeat (3) tick();

    // Annul ALU r9; then annul together with stall
    drive(1'b1, 5'd9, 2'b01, 1'b0, 1'b0, 1'b1);
    tick();
    check_tags("an.c1", BUB, BUB, BUB);
    check("an.acnt1", annul_cnt, cexp(32'd1));
    drive(1'b1, 5'd9, 2'b01, 1'b1, 1'b0, 1'b1);
    tick();
    check("an.acnt2", annul_cnt, cexp(32'd1));
    check("an.scnt", stall_cnt, cexp(32'd3));
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wb($sformatf("an.wb%0d", i), 1'b0, 5'd0);
    end

    // Writes to r31 and class NONE never produce a tag
    drive(1'b1, 5'd31, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check("r31.aP0", 32'(bus.aP0), 32'(BUB));
    drive(1'b1, 5'd31, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    check("r31ld.aP0", 32'(bus.aP0), 32'(BUB));
    drive(1'b1, 5'd4, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    check("none.aP0", 32'(bus.aP0), 32'(BUB));
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wb($sformatf("nw.wb%0d", i), 1'b0, 5'd0);
    end

    // Reset with a full pipe while stall and mem_wait are high
    drive(1'b1, 5'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    check_tags("pre.rst", 7'h03, 7'h42, 7'h21);
    drive(1'b1, 5'd3, 2'b00, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    check_tags("mrst", BUB, BUB, BUB);
    check("mrst.we", 32'(bus.wb_we), 32'd0);
    check("mrst.scnt", stall_cnt, 32'd0);
    check("mrst.acnt", annul_cnt, 32'd0);
    tick();
    check_tags("mrst.n", BUB, BUB, BUB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
